// File: rtl/fp_normalize_round_pack.sv
// fp_normalize_round_pack: final stage of the pipelined FP add/sub unit.
//
// Takes the sign, biased exponent and raw aligned-sum mantissa
// {carry, hidden, fraction, guard, round, sticky}. It normalizes the mantissa,
// rounds to nearest-even and packs an IEEE-754 single result.
//
// The datapath has two stages:
//   A: normalize
//   B: round and pack
// Both sides use valid/ready flow control. The unit sustains one beat per
// clock, and latency from accept to OutValid is 2 clocks.
//
// Optional feature: define FP_PACK_EXCEPTION_FLAGS_EN to register the
// Overflow, Underflow and Inexact flags alongside Result. Without it, the
// three flag outputs are tied to 0. Result values are identical in both
// builds.
//
// Ports:
//   Clk, Rst_n        clock (rising edge); asynchronous active-low reset
//   InValid/InReady   input handshake; InReady is combinational
//   InSign            result sign
//   InExponent        biased exponent of the larger operand
//   InMantissa        aligned sum: bit27 carry, bit26 hidden, 25..3 fraction,
//                     bit2 G, bit1 R, bit0 S
//   OutValid/OutReady output handshake; outputs hold while stalled
//   Result            packed {sign, exponent, fraction}
//   Overflow          result saturated to infinity
//   Underflow         result flushed to zero
//   Inexact           G|R|S nonzero after normalization, or flush/saturate
module fp_normalize_round_pack #(
    parameter int unsigned DataSize     = 32,
    parameter int unsigned FractionSize = 23,
    parameter int unsigned ExponentSize = 8,
    parameter int unsigned MantSumSize  = 28
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    InSign,
    input  logic [ExponentSize-1:0] InExponent,
    input  logic [MantSumSize-1:0]  InMantissa,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [DataSize-1:0]     Result,
    output logic                    Overflow,
    output logic                    Underflow,
    output logic                    Inexact
);

    // Normalized mantissa: {hidden, fraction, G, R, S}
    localparam int unsigned NormW    = MantSumSize - 1;
    localparam int unsigned ExpW     = ExponentSize + 2;
    localparam int unsigned LzW      = $clog2(MantSumSize);
    localparam int unsigned FracSumW = FractionSize + 1;
    localparam logic signed [ExpW-1:0] ExpMax = ExpW'((1 << ExponentSize) - 1);

    // Handshake
    logic ready_a, ready_b;
    logic a_valid_q, a_valid_d;
    logic b_valid_q, b_valid_d;

    assign ready_b  = ~b_valid_q | OutReady;
    assign ready_a  = ~a_valid_q | ready_b;
    assign InReady  = ready_a;
    assign OutValid = b_valid_q;

    // ---------------- Stage A: normalize ----------------
    logic [LzW-1:0]         lz;
    logic                   lz_found;
    logic                   mant_zero;
    logic [NormW-1:0]       norm;
    logic signed [ExpW-1:0] norm_exp;
    logic                   norm_sign;
    logic                   norm_unf;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = int'(NormW) - 1; i >= 0; i--) begin
            if (!lz_found && InMantissa[i]) begin
                lz       = LzW'(int'(NormW) - 1 - i);
                lz_found = 1'b1;
            end
        end

        mant_zero = (InMantissa == '0);

        if (InMantissa[MantSumSize-1]) begin
            // Carry out: shift right one; the dropped bit folds into sticky.
            norm     = {InMantissa[MantSumSize-1:2], InMantissa[1] | InMantissa[0]};
            norm_exp = ExpW'({2'b00, InExponent}) + ExpW'(1);
        end else begin
            norm     = InMantissa[NormW-1:0] << lz;
            norm_exp = ExpW'({2'b00, InExponent}) - ExpW'(lz);
        end

        // Exact cancellation always gives +0.
        norm_sign = InSign & ~mant_zero;
        norm_unf  = ~mant_zero & (norm_exp <= 0);
    end

    logic                   a_sign_q, a_sign_d;
    logic signed [ExpW-1:0] a_exp_q, a_exp_d;
    logic [NormW-1:0]       a_mant_q, a_mant_d;
    logic                   a_unf_q, a_unf_d;

    always_comb begin
        a_valid_d = a_valid_q;
        a_sign_d  = a_sign_q;
        a_exp_d   = a_exp_q;
        a_mant_d  = a_mant_q;
        a_unf_d   = a_unf_q;
        if (ready_a) begin
            a_valid_d = InValid;
        end
        if (InValid && ready_a) begin
            a_sign_d = norm_sign;
            a_exp_d  = norm_exp;
            a_mant_d = norm;
            a_unf_d  = norm_unf;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_valid_q <= 1'b0;
            a_sign_q  <= 1'b0;
            a_exp_q   <= '0;
            a_mant_q  <= '0;
            a_unf_q   <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            a_sign_q  <= a_sign_d;
            a_exp_q   <= a_exp_d;
            a_mant_q  <= a_mant_d;
            a_unf_q   <= a_unf_d;
        end
    end

    // ---------------- Stage B: round and pack ----------------
    logic                   b_zero;
    logic                   rnd_inc;
    logic [FracSumW-1:0]    frac_sum;
    logic signed [ExpW-1:0] rnd_exp;
    logic                   rnd_ovf;
    logic [DataSize-1:0]    pack;

    always_comb begin
        // A zero mantissa is the only case that leaves the hidden bit clear.
        b_zero   = ~a_mant_q[NormW-1];
        rnd_inc  = a_mant_q[2] & (a_mant_q[1] | a_mant_q[0] | a_mant_q[3]);
        frac_sum = {1'b0, a_mant_q[NormW-2:3]} + FracSumW'(rnd_inc);
        // An all-ones fraction that rounds up reaches 2.0; its fraction bits
        // are already zero, so only the exponent moves.
        rnd_exp  = a_exp_q + ExpW'(frac_sum[FractionSize]);
        rnd_ovf  = (rnd_exp >= ExpMax);

        if (b_zero) begin
            pack = '0;
        end else if (a_unf_q) begin
            pack = {a_sign_q, {(DataSize-1){1'b0}}};
        end else if (rnd_ovf) begin
            pack = {a_sign_q, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
        end else begin
            pack = {a_sign_q, rnd_exp[ExponentSize-1:0], frac_sum[FractionSize-1:0]};
        end
    end

    logic [DataSize-1:0] result_q, result_d;
    logic                b_load;

    assign b_load = a_valid_q & ready_b;

    always_comb begin
        b_valid_d = b_valid_q;
        result_d  = result_q;
        if (ready_b) begin
            b_valid_d = a_valid_q;
        end
        if (b_load) begin
            result_d = pack;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            b_valid_q <= 1'b0;
            result_q  <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            result_q  <= result_d;
        end
    end

    assign Result = result_q;

`ifdef FP_PACK_EXCEPTION_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic inx_q, inx_d;
    logic flag_ovf, flag_unf, flag_inx;

    always_comb begin
        flag_ovf = ~b_zero & ~a_unf_q & rnd_ovf;
        flag_unf = a_unf_q;
        flag_inx = flag_ovf | flag_unf |
                   (~b_zero & (a_mant_q[2] | a_mant_q[1] | a_mant_q[0]));
        ovf_d = ovf_q;
        unf_d = unf_q;
        inx_d = inx_q;
        if (b_load) begin
            ovf_d = flag_ovf;
            unf_d = flag_unf;
            inx_d = flag_inx;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
        end
    end

    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Inexact   = inx_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
    assign Inexact   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_normalize_round_pack.sv
// Testbench for fp_normalize_round_pack.
//
// The bench keeps an arithmetic reference model and a scoreboard queue. A
// negedge monitor records every accepted beat and checks every delivered
// result in order. It also checks that outputs hold steady while the
// output side is stalled.
//
// Directed sections cover:
//   - reset state
//   - model pinning against hand-computed values
//   - latency
//   - backpressure
//   - reset while data is in flight
//
// Randomized traffic is run with random downstream stalls.
module tb_fp_normalize_round_pack;

`ifdef FP_PACK_EXCEPTION_FLAGS_EN
    localparam bit FlagsOn = 1'b1;
`else
    localparam bit FlagsOn = 1'b0;
`endif

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic        InSign;
    logic [7:0]  InExponent;
    logic [27:0] InMantissa;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] Result;
    logic        Overflow;
    logic        Underflow;
    logic        Inexact;

    fp_normalize_round_pack dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .InValid    (InValid),
        .InReady    (InReady),
        .InSign     (InSign),
        .InExponent (InExponent),
        .InMantissa (InMantissa),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Result     (Result),
        .Overflow   (Overflow),
        .Underflow  (Underflow),
        .Inexact    (Inexact)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int out_cnt = 0;
    int ready_mode = 1;  // 0: stall, 1: always ready, 2: random

    logic [34:0] sb[$];
    logic [34:0] held;
    bit          held_v = 1'b0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    // Reference: value-level normalize, round-to-nearest-even, pack.
    function automatic logic [34:0] model(input logic s, input logic [7:0] e_in,
                                          input logic [27:0] m_in);
        longint      m;
        longint      kept;
        int          e;
        int          grs;
        logic [31:0] r;
        bit          o, u, x;
        m = longint'(m_in);
        e = int'(e_in);
        o = 0; u = 0; x = 0;
        if (m == 0) begin
            r = 32'h0;
        end else begin
            if (m >= (longint'(1) << 27)) begin
                m = (m >> 1) | (m & 1);
                e = e + 1;
            end else begin
                while (m < (longint'(1) << 26)) begin
                    m = m << 1;
                    e = e - 1;
                end
            end
            if (e <= 0) begin
                r = {s, 31'b0};
                u = 1; x = 1;
            end else begin
                grs  = int'(m & 7);
                kept = m >> 3;
                x    = (grs != 0);
                if (grs > 4 || (grs == 4 && (kept & 1) == 1)) kept = kept + 1;
                if (kept == (longint'(1) << 24)) begin
                    kept = longint'(1) << 23;
                    e = e + 1;
                end
                if (e >= 255) begin
                    r = {s, 8'hFF, 23'b0};
                    o = 1; x = 1;
                end else begin
                    r = {s, 8'(e), 23'(kept)};
                end
            end
        end
        if (!FlagsOn) begin
            o = 0; u = 0; x = 0;
        end
        return {r, o, u, x};
    endfunction

    always @(posedge Clk) begin
        #2;
        case (ready_mode)
            0:       OutReady = 1'b0;
            1:       OutReady = 1'b1;
            default: OutReady = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: handshakes are sampled mid-cycle, ahead of the edge they complete on.
    always @(negedge Clk) begin
        logic [34:0] act;
        logic [34:0] expv;
        act = {Result, Overflow, Underflow, Inexact};
        if (!Rst_n) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", {34'b0, OutValid}, 35'd1);
                chk("hold_data", act, held);
            end
            held_v = 1'b0;
            if (OutValid) begin
                if (OutReady) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", {34'b0, OutValid}, 35'd0);
                    end else begin
                        expv = sb.pop_front();
                        chk("result", act, expv);
                        out_cnt++;
                    end
                end else begin
                    held_v = 1'b1;
                    held   = act;
                end
            end
            if (InValid && InReady) sb.push_back(model(InSign, InExponent, InMantissa));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
        int n;
        InSign = s; InExponent = e; InMantissa = m; InValid = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!InReady && n < 200);
        if (!InReady) chk("send_timeout", {34'b0, InReady}, 35'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 1;
        repeat (8) @(posedge Clk);
        #1;
        chk("drain_sb_empty", 35'(sb.size()), 35'd0);
        chk("drain_outvalid", {34'b0, OutValid}, 35'd0);
    endtask

    function automatic logic [27:0] rand_mant();
        case ($urandom_range(0, 6))
            0:       return 28'($urandom);
            1:       return {1'b1, 27'($urandom)};
            2:       return 28'($urandom) >> $urandom_range(1, 27);
            3:       return {2'b01, 23'($urandom), 3'b100};
            4:       return {2'b01, 23'h7FFFFF, 3'($urandom)};
            5:       return ($urandom_range(0, 3) == 0) ? 28'h0 : {1'b1, 27'h7FFFFFF};
            default: return {2'b01, 26'($urandom)};
        endcase
    endfunction

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(1, 254));
            1:       return 8'($urandom_range(0, 28));
            default: return 8'($urandom_range(240, 254));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    initial begin
        int idx;
        int cnt0;
        logic [27:0] bp_mant[3];
        Rst_n = 1'b0; InValid = 1'b0; InSign = 1'b0; InExponent = '0; InMantissa = '0;
        repeat (2) @(negedge Clk);
        chk("reset_outvalid", {34'b0, OutValid}, 35'd0);
        chk("reset_outputs", {Result, Overflow, Underflow, Inexact}, 35'd0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Pin the model to hand-computed values.
        chk("model_3p0", model(1'b0, 8'h7F, 28'hC000000), {32'h40400000, 3'b000});
        chk("model_zero", model(1'b1, 8'h55, 28'h0000000), {32'h00000000, 3'b000});
        chk("model_half", model(1'b0, 8'h80, 28'h1000000), {32'h3F000000, 3'b000});
        chk("model_tie_odd", model(1'b0, 8'h7F, 28'h400000C), {32'h3F800002, 2'b00, FlagsOn});
        chk("model_tie_even", model(1'b0, 8'h7F, 28'h4000004), {32'h3F800000, 2'b00, FlagsOn});
        chk("model_ovf", model(1'b0, 8'hFE, 28'h8000000), {32'h7F800000, FlagsOn, 1'b0, FlagsOn});
        chk("model_unf", model(1'b0, 8'h01, 28'h2000000), {32'h00000000, 1'b0, FlagsOn, FlagsOn});

        // Latency: accept on edge P0, OutValid visible after edge P1.
        InSign = 1'b0; InExponent = 8'h7F; InMantissa = 28'hC000000; InValid = 1'b1;
        @(negedge Clk);
        chk("lat_inready", {34'b0, InReady}, 35'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(negedge Clk);
        chk("lat_not_yet", {34'b0, OutValid}, 35'd0);
        @(negedge Clk);
        chk("lat_valid", {34'b0, OutValid}, 35'd1);
        chk("lat_result", {3'b0, Result}, {3'b0, 32'h40400000});
        @(posedge Clk);
        #1;

        send(1'b1, 8'h33, 28'h0000000);
        send(1'b0, 8'h80, 28'h1000000);
        send(1'b0, 8'h7F, 28'h400000C);
        send(1'b0, 8'h7F, 28'h4000004);
        send(1'b0, 8'hFE, 28'h8000000);
        send(1'b0, 8'h01, 28'h2000000);
        send(1'b1, 8'h01, 28'h2000000);
        drain();

        // Backpressure: only two beats fit while the output is stalled.
        bp_mant[0] = 28'h4000001; bp_mant[1] = 28'h8000003; bp_mant[2] = 28'h0123456;
        ready_mode = 0;
        cnt0 = out_cnt;
        idx = 0;
        InSign = 1'b0; InExponent = 8'h90; InMantissa = bp_mant[0]; InValid = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            if (InReady && idx < 3) idx++;
            @(posedge Clk);
            #1;
            if (idx < 3) InMantissa = bp_mant[idx];
        end
        chk("bp_accepts", 35'(idx), 35'd2);
        @(negedge Clk);
        chk("bp_inready_low", {34'b0, InReady}, 35'd0);
        @(posedge Clk);
        #1;
        ready_mode = 1;
        send(1'b0, 8'h90, bp_mant[2]);
        drain();
        chk("bp_out_count", 35'(out_cnt - cnt0), 35'd3);

        // Randomized traffic with random stalls.
        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            send(1'($urandom), rand_exp(), rand_mant());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk);
                #1;
            end
        end
        drain();

        // Reset with beats in flight discards them.
        ready_mode = 0;
        send(1'b0, 8'h7F, 28'h4000000);
        send(1'b1, 8'h80, 28'h4000000);
        @(negedge Clk);
        chk("rst_pre_valid", {34'b0, OutValid}, 35'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_outvalid", {34'b0, OutValid}, 35'd0);
        chk("rst_outputs", {Result, Overflow, Underflow, Inexact}, 35'd0);
        ready_mode = 1;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        chk("rst_no_partial", {34'b0, OutValid}, 35'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
